// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: definitions shared across the pipeline.
//   - Operand/forwarding selects (RS_DATA, FWD_*), used by the execute stage.
//   - Write-back mux encodings. WB_MEM marks a load.
//   - funct3 load/store size encodings.
//   - Helpers that decode the access width and build byte lanes.
package mem_stage_pkg;

    // Operand source selects for the execute-stage forwarding muxes
    localparam logic [1:0] RS_DATA = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Write-back source selects
    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    // funct3 size encodings for loads/stores
    localparam logic [2:0] MEM_LB  = 3'b000;
    localparam logic [2:0] MEM_LH  = 3'b001;
    localparam logic [2:0] MEM_LW  = 3'b010;
    localparam logic [2:0] MEM_LBU = 3'b100;
    localparam logic [2:0] MEM_LHU = 3'b101;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } acc_size_e;

    // Any encoding not listed above falls back to a full word access.
    function automatic acc_size_e decode_size(input logic [2:0] f3);
        case (f3)
            MEM_LB, MEM_LBU: return SZ_BYTE;
            MEM_LH, MEM_LHU: return SZ_HALF;
            default:         return SZ_WORD;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input acc_size_e sz, input logic [1:0] off);
        case (sz)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Store data goes out on every lane, so the slave picks lanes purely by byte enable
    function automatic logic [31:0] replicate(input acc_size_e sz, input logic [31:0] d);
        case (sz)
            SZ_BYTE: return {4{d[7:0]}};
            SZ_HALF: return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// mem_stage_load_align: combinational load data alignment.
// Picks the addressed byte or halfword out of the bus word, then sign- or
// zero-extends it according to funct3.
//   rdata  in  32  raw word from the data bus
//   offset in  2   address bits [1:0]
//   size   in  3   funct3 (unknown encodings behave as LW)
//   data   out 32  aligned, extended load value
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  size,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (size)
            MEM_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            MEM_LBU: data = {24'd0, byte_sel};
            MEM_LH:  data = {{16{half_sel[15]}}, half_sel};
            MEM_LHU: data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage with a ready/valid-style data bus.
// Non-memory ops pass to write-back with one cycle of latency. Loads and
// stores raise dmem_req in the same cycle they arrive. While the bus holds
// off, stall freezes upstream, which keeps the request inputs constant.
// A misaligned access is never issued. A bus that never answers is
// abandoned after TIMEOUT_CYCLES stalled cycles. Both of these cases
// produce a one-cycle mem_err pulse and a write-back bubble.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   alu_result, store_data     address/result and rs2 from execute
//   mem_size                   funct3 access size
//   rd_addr, reg_write, mem_write, wb_mux  control from execute
//   dmem_req/we/addr/wdata/be  data bus request (req is combinational)
//   dmem_ready, dmem_rdata     data bus response
//   stall                      freeze upstream stages
//   rd_addr_out, reg_write_out, wb_data_out, wb_mux_out  to write-back
//   mem_err                    misaligned/timeout pulse
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [2:0]  mem_size,
    input  logic [4:0]  rd_addr,
    input  logic        reg_write,
    input  logic        mem_write,
    input  logic [1:0]  wb_mux,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [4:0]  rd_addr_out,
    output logic        reg_write_out,
    output logic [31:0] wb_data_out,
    output logic [1:0]  wb_mux_out,
    output logic        mem_err
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_e;

    // The issue cycle in IDLE counts as one waiting cycle. WAIT therefore
    // gives up once the counter reaches TIMEOUT_CYCLES-1. That gives
    // exactly TIMEOUT_CYCLES stalled cycles before the abort.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic        reg_write_q, reg_write_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [1:0]  wb_mux_q, wb_mux_d;
    logic        mem_err_q, mem_err_d;

    acc_size_e   acc_size;
    logic [1:0]  offset;
    logic        mem_op;
    logic        misaligned;
    logic        timeout_hit;
    logic        req;
    logic [31:0] load_data;

    assign acc_size    = decode_size(mem_size);
    assign offset      = alu_result[1:0];
    assign mem_op      = mem_write | (wb_mux == WB_MEM);
    assign misaligned  = mem_op & (((acc_size == SZ_HALF) & offset[0]) |
                                   ((acc_size == SZ_WORD) & (offset != 2'b00)));
    assign timeout_hit = (state_q == WAIT) && (cnt_q == TO_LAST);

    // rst_n gates the request so that nothing reaches the bus during reset
    assign req        = rst_n & mem_op & ~misaligned & ~timeout_hit;
    assign dmem_req   = req;
    assign dmem_we    = mem_write;
    assign dmem_addr  = {alu_result[31:2], 2'b00};
    assign dmem_be    = byte_enables(acc_size, offset);
    assign dmem_wdata = replicate(acc_size, store_data);
    assign stall      = req & ~dmem_ready;

    mem_stage_load_align u_load_align (
        .rdata  (dmem_rdata),
        .offset (offset),
        .size   (mem_size),
        .data   (load_data)
    );

    // Bus handshake FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req && !dmem_ready) begin
                    state_d = WAIT;
                    cnt_d   = 8'd0;
                end
            end
            WAIT: begin
                if (dmem_ready || timeout_hit) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Write-back register. The default is a bubble. Only a completed
    // non-memory op or a completed load writes.
    always_comb begin
        rd_addr_d   = rd_addr;
        wb_mux_d    = wb_mux;
        wb_data_d   = alu_result;
        reg_write_d = 1'b0;
        mem_err_d   = 1'b0;
        if (!mem_op) begin
            reg_write_d = reg_write;
        end else if (misaligned || timeout_hit) begin
            mem_err_d = 1'b1;
        end else if (dmem_ready && !mem_write) begin
            reg_write_d = reg_write;
            wb_data_d   = load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            rd_addr_q   <= 5'd0;
            reg_write_q <= 1'b0;
            wb_data_q   <= 32'd0;
            wb_mux_q    <= 2'd0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_addr_q   <= rd_addr_d;
            reg_write_q <= reg_write_d;
            wb_data_q   <= wb_data_d;
            wb_mux_q    <= wb_mux_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign rd_addr_out   = rd_addr_q;
    assign reg_write_out = reg_write_q;
    assign wb_data_out   = wb_data_q;
    assign wb_mux_out    = wb_mux_q;
    assign mem_err       = mem_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed table-driven bench for mem_stage (TIMEOUT_CYCLES=4),
// plus hand-written sequences for wait states, timeout and reset mid-access.
module tb_mem_stage;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] alu_result, store_data, dmem_rdata;
    logic [2:0]  mem_size;
    logic [4:0]  rd_addr;
    logic        reg_write, mem_write, dmem_ready;
    logic [1:0]  wb_mux;
    logic        dmem_req, dmem_we, stall, reg_write_out, mem_err;
    logic [31:0] dmem_addr, dmem_wdata, wb_data_out;
    logic [3:0]  dmem_be;
    logic [4:0]  rd_addr_out;
    logic [1:0]  wb_mux_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_result(alu_result), .store_data(store_data), .mem_size(mem_size),
        .rd_addr(rd_addr), .reg_write(reg_write), .mem_write(mem_write), .wb_mux(wb_mux),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .stall(stall), .rd_addr_out(rd_addr_out), .reg_write_out(reg_write_out),
        .wb_data_out(wb_data_out), .wb_mux_out(wb_mux_out), .mem_err(mem_err)
    );

    typedef struct {
        logic [31:0] alu;
        logic [31:0] sd;
        logic [2:0]  sz;
        logic [4:0]  rd;
        logic        rw;
        logic        mw;
        logic [1:0]  wbm;
        logic        rdy;
        logic [31:0] rdata;
        logic        e_req;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_stall;
        logic [31:0] e_wb;
        logic        e_rw;
        logic        e_err;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] sd, input logic [2:0] sz,
                         input logic [4:0] rd, input logic rw, input logic mw,
                         input logic [1:0] wbm, input logic rdy, input logic [31:0] rdata);
        alu_result = alu; store_data = sd; mem_size = sz; rd_addr = rd;
        reg_write = rw; mem_write = mw; wb_mux = wbm; dmem_ready = rdy; dmem_rdata = rdata;
    endtask

    vec_t v[15];

    initial begin
        int  n;
        bit  done;

        // Table columns: alu, sd, sz, rd, rw, mw, wbm, rdy, rdata | req, be, wdata, stall, wb, rw_o, err
        v[0]  = '{32'h0000_1234, 32'h0, 3'b000, 5'd5,  1'b1, 1'b0, WB_ALU, 1'b0, 32'h0,
                  1'b0, 4'b0000, 32'h0,         1'b0, 32'h0000_1234, 1'b1, 1'b0};
        v[1]  = '{32'h0000_0103, 32'h0, 3'b000, 5'd6,  1'b1, 1'b0, WB_MEM, 1'b1, 32'h80FF_FFFF,
                  1'b1, 4'b1000, 32'h0,         1'b0, 32'hFFFF_FF80, 1'b1, 1'b0};
        v[2]  = '{32'h0000_0101, 32'h0, 3'b100, 5'd7,  1'b1, 1'b0, WB_MEM, 1'b1, 32'h1234_5678,
                  1'b1, 4'b0010, 32'h0,         1'b0, 32'h0000_0056, 1'b1, 1'b0};
        v[3]  = '{32'h0000_0102, 32'h0, 3'b001, 5'd8,  1'b1, 1'b0, WB_MEM, 1'b1, 32'h8001_0000,
                  1'b1, 4'b1100, 32'h0,         1'b0, 32'hFFFF_8001, 1'b1, 1'b0};
        v[4]  = '{32'h0000_0100, 32'h0, 3'b101, 5'd9,  1'b1, 1'b0, WB_MEM, 1'b1, 32'h1234_F00D,
                  1'b1, 4'b0011, 32'h0,         1'b0, 32'h0000_F00D, 1'b1, 1'b0};
        v[5]  = '{32'h0000_0200, 32'h0, 3'b010, 5'd10, 1'b1, 1'b0, WB_MEM, 1'b1, 32'hDEAD_BEEF,
                  1'b1, 4'b1111, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0};
        v[6]  = '{32'h0000_0201, 32'h1234_5678, 3'b000, 5'd1, 1'b1, 1'b1, WB_ALU, 1'b1, 32'h0,
                  1'b1, 4'b0010, 32'h7878_7878, 1'b0, 32'h0,         1'b0, 1'b0};
        v[7]  = '{32'h0000_0204, 32'hCAFE_F00D, 3'b010, 5'd0, 1'b0, 1'b1, WB_ALU, 1'b1, 32'h0,
                  1'b1, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0,         1'b0, 1'b0};
        v[8]  = '{32'h0000_0206, 32'h0000_BEEF, 3'b001, 5'd0, 1'b0, 1'b1, WB_ALU, 1'b1, 32'h0,
                  1'b1, 4'b1100, 32'hBEEF_BEEF, 1'b0, 32'h0,         1'b0, 1'b0};
        v[9]  = '{32'h0000_0101, 32'h0, 3'b010, 5'd11, 1'b1, 1'b0, WB_MEM, 1'b0, 32'h0,
                  1'b0, 4'b0000, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1};
        v[10] = '{32'h0000_0103, 32'h0, 3'b001, 5'd11, 1'b1, 1'b0, WB_MEM, 1'b0, 32'h0,
                  1'b0, 4'b0000, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1};
        v[11] = '{32'h0000_0208, 32'h0, 3'b111, 5'd12, 1'b1, 1'b0, WB_MEM, 1'b1, 32'h0102_0304,
                  1'b1, 4'b1111, 32'h0,         1'b0, 32'h0102_0304, 1'b1, 1'b0};
        v[12] = '{32'h0000_020A, 32'h0, 3'b011, 5'd13, 1'b1, 1'b0, WB_MEM, 1'b0, 32'h0,
                  1'b0, 4'b0000, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1};
        v[13] = '{32'h0000_0044, 32'h0, 3'b000, 5'd14, 1'b1, 1'b0, WB_PC4, 1'b0, 32'h0,
                  1'b0, 4'b0000, 32'h0,         1'b0, 32'h0000_0044, 1'b1, 1'b0};
        v[14] = '{32'h0000_0055, 32'h0, 3'b000, 5'd15, 1'b0, 1'b0, WB_ALU, 1'b0, 32'h0,
                  1'b0, 4'b0000, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0};

        // Reset with an aligned load presented: nothing may reach the bus
        rst_n = 1'b0;
        drive(32'h100, 32'h0, 3'b010, 5'd3, 1'b1, 1'b0, WB_MEM, 1'b0, 32'h0);
        #2;
        chk("rst dmem_req", 32'(dmem_req), 32'd0);
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst reg_write_out", 32'(reg_write_out), 32'd0);
        chk("rst wb_data_out", wb_data_out, 32'd0);
        chk("rst rd_addr_out", 32'(rd_addr_out), 32'd0);
        chk("rst wb_mux_out", 32'(wb_mux_out), 32'd0);
        chk("rst mem_err", 32'(mem_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-cycle vectors
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(v[i].alu, v[i].sd, v[i].sz, v[i].rd, v[i].rw, v[i].mw, v[i].wbm, v[i].rdy, v[i].rdata);
            #1;
            chk($sformatf("v%0d dmem_req", i), 32'(dmem_req), 32'(v[i].e_req));
            chk($sformatf("v%0d stall", i), 32'(stall), 32'(v[i].e_stall));
            if (v[i].e_req) begin
                chk($sformatf("v%0d dmem_be", i), 32'(dmem_be), 32'(v[i].e_be));
                chk($sformatf("v%0d dmem_addr", i), dmem_addr, {v[i].alu[31:2], 2'b00});
                chk($sformatf("v%0d dmem_we", i), 32'(dmem_we), 32'(v[i].mw));
                if (v[i].mw)
                    chk($sformatf("v%0d dmem_wdata", i), dmem_wdata, v[i].e_wdata);
            end
            @(posedge clk);
            #1;
            chk($sformatf("v%0d reg_write_out", i), 32'(reg_write_out), 32'(v[i].e_rw));
            chk($sformatf("v%0d mem_err", i), 32'(mem_err), 32'(v[i].e_err));
            if (v[i].e_rw) begin
                chk($sformatf("v%0d wb_data_out", i), wb_data_out, v[i].e_wb);
                chk($sformatf("v%0d rd_addr_out", i), 32'(rd_addr_out), 32'(v[i].rd));
                chk($sformatf("v%0d wb_mux_out", i), 32'(wb_mux_out), 32'(v[i].wbm));
            end
        end

        // SH 0x102, ready on the 4th cycle: three stalled cycles with the bus held steady
        n = 0; done = 0;
        for (int c = 0; c < 12 && !done; c++) begin
            @(negedge clk);
            drive(32'h102, 32'h0000_ABCD, 3'b001, 5'd2, 1'b0, 1'b1, WB_ALU, (c >= 3), 32'h0);
            #1;
            chk("sh dmem_be", 32'(dmem_be), 32'h0000_000C);
            chk("sh dmem_wdata", dmem_wdata, 32'hABCD_ABCD);
            chk("sh dmem_req", 32'(dmem_req), 32'd1);
            if (stall) n++; else done = 1;
            @(posedge clk);
            #1;
            chk("sh reg_write_out", 32'(reg_write_out), 32'd0);
        end
        chk("sh completed", 32'(done), 32'd1);
        chk("sh stall cycles", 32'(n), 32'd3);
        chk("sh mem_err", 32'(mem_err), 32'd0);

        // LHU that never gets ready: aborted after 4 stalled cycles
        n = 0; done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            drive(32'h100, 32'h0, 3'b101, 5'd3, 1'b1, 1'b0, WB_MEM, 1'b0, 32'h0);
            #1;
            if (stall) n++;
            else begin
                done = 1;
                chk("to dmem_req released", 32'(dmem_req), 32'd0);
            end
            @(posedge clk);
            #1;
            chk("to reg_write_out", 32'(reg_write_out), 32'd0);
        end
        chk("to released", 32'(done), 32'd1);
        chk("to stall cycles", 32'(n), 32'd4);
        chk("to mem_err pulse", 32'(mem_err), 32'd1);
        @(negedge clk);
        drive(32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0, WB_ALU, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        chk("to mem_err drop", 32'(mem_err), 32'd0);
        // Back in IDLE: a zero-wait LW completes without stalling
        @(negedge clk);
        drive(32'h300, 32'h0, 3'b010, 5'd9, 1'b1, 1'b0, WB_MEM, 1'b1, 32'h5566_7788);
        #1;
        chk("to idle stall", 32'(stall), 32'd0);
        chk("to idle dmem_req", 32'(dmem_req), 32'd1);
        @(posedge clk);
        #1;
        chk("to idle wb_data_out", wb_data_out, 32'h5566_7788);

        // Reset asserted while in WAIT
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive(32'h400, 32'h0, 3'b010, 5'd4, 1'b1, 1'b0, WB_MEM, 1'b0, 32'h0);
            @(posedge clk);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rw dmem_req", 32'(dmem_req), 32'd0);
        chk("rw stall", 32'(stall), 32'd0);
        chk("rw reg_write_out", 32'(reg_write_out), 32'd0);
        chk("rw wb_data_out", wb_data_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h400, 32'h0, 3'b010, 5'd4, 1'b1, 1'b0, WB_MEM, 1'b1, 32'h1122_3344);
        #1;
        chk("rw new dmem_req", 32'(dmem_req), 32'd1);
        chk("rw new stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        chk("rw new wb_data_out", wb_data_out, 32'h1122_3344);
        chk("rw new reg_write_out", 32'(reg_write_out), 32'd1);
        chk("rw new rd_addr_out", 32'(rd_addr_out), 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning max wait cycles for dmem_ready before abort (range 1..255).
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- alu_result  in  32  address or ALU result from execute register
- store_data  in  32  rs2 value from execute register
- mem_size  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- rd_addr  in  5  destination register
- reg_write  in  1  write-back enable
- mem_write  in  1  store request
- wb_mux  in  2  write-back select; WB_MEM marks a load
- dmem_req  out  1  bus request
- dmem_we  out  1  bus write
- dmem_addr  out  32  word-aligned address, {alu_result[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ready  in  1  bus completion (same-cycle allowed)
- dmem_rdata  in  32  load word, valid with dmem_ready
- stall  out  1  freeze upstream stages
- rd_addr_out  out  5  to write-back
- reg_write_out  out  1  to write-back
- wb_data_out  out  32  loaded or passed-through value
- wb_mux_out  out  2  to write-back
- mem_err  out  1  one-cycle pulse: misaligned or timeout

Function
REQ-003 SHALL treat the input as memory op when mem_write=1 or wb_mux=WB_MEM; otherwise non-memory.
REQ-004 SHALL pass non-memory ops with 1-cycle latency: wb_data_out<=alu_result; rd/reg_write/wb_mux registered.
REQ-005 SHALL generate dmem_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
REQ-006 SHALL replicate store data: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
REQ-007 SHALL be misaligned when half with addr[0]=1 or word with addr[1:0]!=0; SHALL then keep dmem_req=0, pulse mem_err, register a bubble (reg_write_out=0), no stall.
REQ-008 SHALL use FSM states IDLE, WAIT; dmem_req=1 combinationally in IDLE for aligned memory op, and held in WAIT with constant addr/we/be/wdata.
REQ-009 IDLE->WAIT when request issued and dmem_ready=0; WAIT->IDLE on dmem_ready=1 or timeout.
REQ-010 SHALL assert stall = dmem_req & ~dmem_ready; zero-wait access (ready same cycle as req) SHALL not stall.
REQ-011 SHALL register bubble (reg_write_out=0) on every stalled cycle.
REQ-012 On completion SHALL register load result selected by addr[1:0], sign-extended (LB/LH) or zero-extended (LBU/LHU); stores register reg_write_out=0.
REQ-013 SHALL count WAIT cycles with 8-bit counter cleared on entry; reaching TIMEOUT_CYCLES SHALL drop dmem_req, pulse mem_err, deassert stall, register bubble, return IDLE.
REQ-014 Unknown mem_size SHALL be treated as LW.

Reset
REQ-015 SHALL on rst_n=0 asynchronously: state IDLE, counter 0, rd_addr_out 0, reg_write_out 0, wb_data_out 0, wb_mux_out 0, mem_err 0.
REQ-016 Reset mid-WAIT SHALL abandon the access; dmem_req SHALL be 0 while rst_n=0.

Structure
REQ-017 SHALL take WB_MEM and mem_size encodings from shared defs file alongside existing RS_DATA/FWD_* defines; FSM state encodings local.
REQ-018 SHALL instantiate one sub-module load_align (combinational extract/extend of dmem_rdata by addr[1:0], mem_size).

Verification
REQ-019 ADD result 0x0000_1234, rd=5 -> next cycle wb_data_out=0x1234, reg_write_out=1, no dmem_req.
REQ-020 LB addr 0x103, ready same cycle, rdata 0x80FF_FFFF -> be=4'b1000, no stall, wb_data_out=0xFFFF_FF80.
REQ-021 SH addr 0x102, data 0xABCD, ready after 3 cycles -> stall 3 cycles, be=4'b1100, wdata=0xABCD_ABCD, reg_write_out=0.
REQ-022 LW addr 0x101 -> no dmem_req, mem_err one cycle, reg_write_out=0.
REQ-023 LHU, TIMEOUT_CYCLES=4, ready never -> stall 4 cycles then release, mem_err pulse, state IDLE.
REQ-024 rst_n low during WAIT -> dmem_req, stall, reg_write_out immediately 0; after release new LW completes normally.
